// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the read-initiator state type.
package axi_pkg;

  // AxBURST encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // xRESP codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A burst may never cross this byte boundary
  localparam int BOUNDARY_4K = 4096;

  // Normal non-cacheable bufferable memory
  localparam logic [3:0] AXCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // AxSIZE code for a bus of the given byte width
  function automatic logic [2:0] size_code(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beat count of the next burst: the smallest of the words still wanted,
// the burst cap, and the words left before the next 4 KiB boundary.
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]          addr_low,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);

  logic [31:0] to_boundary;
  logic [31:0] rem_ext;
  logic [31:0] cap;

  // Three-way minimum, done in 32 bits so no operand is truncated early
  always_comb begin
    to_boundary = (32'(BOUNDARY_4K) - 32'(addr_low)) >> SIZE;
    rem_ext     = 32'(remaining);
    cap         = 32'(MAX_BURST_LEN);
    if (to_boundary < cap) cap = to_boundary;
    if (rem_ext < cap) cap = rem_ext;
    beats = 9'(cap);
  end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: reads cmd_len words from cmd_addr as a series of
// INCR bursts (one outstanding) and forwards the data on an AXI-Stream port.
module axi_burst_reader
  import axi_pkg::*;
#(
  parameter int              DATA_WIDTH    = 32,
  parameter int              ADDR_WIDTH    = 16,
  parameter int              ID_WIDTH      = 8,
  parameter logic [ID_WIDTH-1:0] ARID_VALUE = '0,
  parameter int              MAX_BURST_LEN = 16,
  parameter int              LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int BPW  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPW);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(BPW - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [8:0]            beats_q, beats_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic [8:0]            calc_beats;

  logic cmd_hs, ar_hs, r_hs, last_beat;

  // Read ID and the sub-word address bits carry no information here
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rid, cmd_addr};

  assign cmd_hs    = (state_q == IDLE) && cmd_valid;
  assign ar_hs     = (state_q == ADDR) && m_axi_arready;
  assign r_hs      = (state_q == DATA) && m_axi_rvalid && m_axis_tready;
  assign last_beat = r_hs && (beat_cnt_q == 9'd1);

  // Sized from the values the next ADDR state will see
  axi_burst_len_calc #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_len_calc (
    .addr_low (addr_d[11:0]),
    .remaining(remaining_d),
    .beats    (calc_beats)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_hs && (cmd_len != '0)) state_d = ADDR;
      ADDR: if (ar_hs) state_d = DATA;
      DATA: if (last_beat) state_d = (remaining_q != '0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, word-count, beat-count, error and done bookkeeping
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    done_d      = 1'b0;
    if (cmd_hs) begin
      addr_d      = cmd_addr & ~ADDR_MASK;
      remaining_d = cmd_len;
      error_d     = 1'b0;
      done_d      = (cmd_len == '0);
    end
    if (ar_hs) begin
      addr_d      = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
      remaining_d = remaining_q - LEN_WIDTH'(beats_q);
      beat_cnt_d  = beats_q;
    end
    if (r_hs) begin
      beat_cnt_d = beat_cnt_q - 9'd1;
      if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != (beat_cnt_q == 9'd1)))
        error_d = 1'b1;
      if (last_beat && (remaining_q == '0))
        done_d = 1'b1;
    end
  end

  // Burst size is captured once on entry to ADDR and held while arvalid is up
  always_comb begin
    beats_d = beats_q;
    arlen_d = arlen_q;
    if ((state_d == ADDR) && (state_q != ADDR)) begin
      beats_d = calc_beats;
      arlen_d = 8'(calc_beats - 9'd1);
    end
  end

  // Outputs decoded from the current state; R passes straight to the stream
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    m_axi_arvalid = (state_q == ADDR);
    m_axi_rready  = (state_q == DATA) && m_axis_tready;
    m_axis_tvalid = (state_q == DATA) && m_axi_rvalid;
    m_axis_tdata  = (state_q == DATA) ? m_axi_rdata : '0;
    m_axis_tlast  = (state_q == DATA) && (beat_cnt_q == 9'd1) && (remaining_q == '0);
  end

  assign done          = done_q;
  assign error         = error_q;
  assign m_axi_arid    = ARID_VALUE;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = size_code(BPW);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXCACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader against a small AXI read slave whose
// memory holds mem[i] = i (word index).
module tb_axi_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, busy, done, error;
  logic [7:0]  m_axi_arid;
  logic [15:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_burst_reader dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .error(error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  // ---------------- AXI read slave (one burst at a time) ----------------
  logic        s_active = 1'b0;
  logic [15:0] s_addr = '0;
  int          s_left = 0;
  int          s_beats_total = 0;
  bit          err_en = 1'b0;
  int          err_at = 0;
  logic [15:0] ar_addr_log [0:63];
  logic [7:0]  ar_len_log [0:63];
  int          ar_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      s_active <= 1'b0;
      s_left   <= 0;
    end else if (!s_active) begin
      if (m_axi_arvalid) begin
        s_active <= 1'b1;
        s_addr   <= m_axi_araddr;
        s_left   <= int'(m_axi_arlen) + 1;
        ar_addr_log[ar_count] <= m_axi_araddr;
        ar_len_log[ar_count]  <= m_axi_arlen;
        ar_count <= ar_count + 1;
      end
    end else if (m_axi_rvalid && m_axi_rready) begin
      s_addr        <= s_addr + 16'd4;
      s_left        <= s_left - 1;
      s_beats_total <= s_beats_total + 1;
      if (s_left == 1) s_active <= 1'b0;
    end
  end

  assign m_axi_arready = !s_active;
  assign m_axi_rvalid  = s_active;
  assign m_axi_rdata   = 32'(s_addr >> 2);
  assign m_axi_rlast   = (s_left == 1);
  assign m_axi_rresp   = (err_en && (s_beats_total == err_at)) ? 2'b10 : 2'b00;
  assign m_axi_rid     = 8'h00;

  // ---------------- monitors ----------------
  int          cycle = 0;
  logic [31:0] rx_data [0:255];
  logic        rx_last [0:255];
  int          rx_cycle [0:255];
  int          rx_count = 0;
  int          done_count = 0;
  int          done_cycle = 0;
  logic        done_err = 1'b0;
  int          acc_cycle = 0;
  int          arv_cycles = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      rx_data[rx_count]  <= m_axis_tdata;
      rx_last[rx_count]  <= m_axis_tlast;
      rx_cycle[rx_count] <= cycle;
      rx_count <= rx_count + 1;
    end
    if (!rst && done) begin
      done_count <= done_count + 1;
      done_cycle <= cycle;
      done_err   <= error;
    end
    if (!rst && cmd_valid && cmd_ready) acc_cycle <= cycle;
    if (m_axi_arvalid) arv_cycles <= arv_cycles + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_cmd(input logic [15:0] a, input logic [15:0] l);
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd addr=0x%04h len=%0d issued", a, l);
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_count > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got=%b%b want=00", done, error); end
    n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_handshakes got=%b%b%b want=000", m_axi_arvalid, m_axi_rready, m_axis_tvalid); end
    n_checks++; if (m_axi_araddr !== 16'h0 || m_axi_arlen !== 8'h0) begin n_fail++; $display("FAIL reset_ar_fields got=%h/%h want=0000/00", m_axi_araddr, m_axi_arlen); end
    n_checks++; if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'b0011 || m_axi_arprot !== 3'b000 || m_axi_arlock !== 1'b0 || m_axi_arid !== 8'h00) begin n_fail++; $display("FAIL reset_ar_const size=%0d burst=%b cache=%b prot=%b lock=%b id=%h", m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arid); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_single_burst();
    int ab = ar_count; int rb = rx_count; int db = done_count; bit ok;
    m_axis_tready = 1'b1;
    issue_cmd(16'h0100, 16'd4);
    wait_done(db, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout got=none want=done"); end
    n_checks++; if (ar_count - ab !== 1) begin n_fail++; $display("FAIL single_ar_count got=%0d want=1", ar_count - ab); end
    n_checks++; if (ar_addr_log[ab] !== 16'h0100 || ar_len_log[ab] !== 8'd3) begin n_fail++; $display("FAIL single_ar got=%h/%0d want=0100/3", ar_addr_log[ab], ar_len_log[ab]); end
    n_checks++; if (rx_count - rb !== 4) begin n_fail++; $display("FAIL single_words got=%0d want=4", rx_count - rb); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rx_data[rb+i] !== 32'h40 + 32'(i) || rx_last[rb+i] !== (i == 3)) begin n_fail++; $display("FAIL single_word%0d got=%h last=%b want=%h last=%b", i, rx_data[rb+i], rx_last[rb+i], 32'h40 + 32'(i), (i == 3)); end
    end
    n_checks++; if (done_cycle !== rx_cycle[rb+3] + 1) begin n_fail++; $display("FAIL single_done_latency got=%0d want=%0d", done_cycle, rx_cycle[rb+3] + 1); end
    n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL single_error got=%b want=0", done_err); end
  endtask

  task automatic test_multi_burst();
    int ab = ar_count; int rb = rx_count; int db = done_count; bit ok; int lasts = 0;
    logic [15:0] exp_a [0:2];
    logic [7:0]  exp_l [0:2];
    exp_a[0] = 16'h0000; exp_a[1] = 16'h0040; exp_a[2] = 16'h0080;
    exp_l[0] = 8'd15;    exp_l[1] = 8'd15;    exp_l[2] = 8'd7;
    issue_cmd(16'h0000, 16'd40);
    wait_done(db, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_done_timeout got=none want=done"); end
    n_checks++; if (ar_count - ab !== 3) begin n_fail++; $display("FAIL multi_ar_count got=%0d want=3", ar_count - ab); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ar_addr_log[ab+k] !== exp_a[k] || ar_len_log[ab+k] !== exp_l[k]) begin n_fail++; $display("FAIL multi_ar%0d got=%h/%0d want=%h/%0d", k, ar_addr_log[ab+k], ar_len_log[ab+k], exp_a[k], exp_l[k]); end
    end
    n_checks++; if (rx_count - rb !== 40) begin n_fail++; $display("FAIL multi_words got=%0d want=40", rx_count - rb); end
    for (int i = 0; i < 40; i++) begin
      if (rx_last[rb+i] === 1'b1) lasts++;
      n_checks++; if (rx_data[rb+i] !== 32'(i)) begin n_fail++; $display("FAIL multi_word%0d got=%h want=%h", i, rx_data[rb+i], 32'(i)); end
    end
    n_checks++; if (lasts !== 1 || rx_last[rb+39] !== 1'b1) begin n_fail++; $display("FAIL multi_tlast got=%0d/%b want=1/1", lasts, rx_last[rb+39]); end
  endtask

  task automatic test_4k_boundary();
    int ab = ar_count; int rb = rx_count; int db = done_count; bit ok;
    issue_cmd(16'h0FF8, 16'd8);
    wait_done(db, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b4k_done_timeout got=none want=done"); end
    n_checks++; if (ar_count - ab !== 2) begin n_fail++; $display("FAIL b4k_ar_count got=%0d want=2", ar_count - ab); end
    n_checks++; if (ar_addr_log[ab] !== 16'h0FF8 || ar_len_log[ab] !== 8'd1) begin n_fail++; $display("FAIL b4k_ar0 got=%h/%0d want=0ff8/1", ar_addr_log[ab], ar_len_log[ab]); end
    n_checks++; if (ar_addr_log[ab+1] !== 16'h1000 || ar_len_log[ab+1] !== 8'd5) begin n_fail++; $display("FAIL b4k_ar1 got=%h/%0d want=1000/5", ar_addr_log[ab+1], ar_len_log[ab+1]); end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (32'(ar_addr_log[ab+k][11:0]) + (32'(ar_len_log[ab+k]) + 1) * 4 > 4096) begin n_fail++; $display("FAIL b4k_cross%0d got=%h/%0d want=no_cross", k, ar_addr_log[ab+k], ar_len_log[ab+k]); end
    end
    n_checks++; if (rx_count - rb !== 8) begin n_fail++; $display("FAIL b4k_words got=%0d want=8", rx_count - rb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rx_data[rb+i] !== 32'h3FE + 32'(i)) begin n_fail++; $display("FAIL b4k_word%0d got=%h want=%h", i, rx_data[rb+i], 32'h3FE + 32'(i)); end
    end
  endtask

  task automatic test_zero_len();
    int ab = ar_count; int vb = arv_cycles; int db = done_count; bit ok;
    issue_cmd(16'h0040, 16'd0);
    wait_done(db, ok);
    repeat (5) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done_timeout got=none want=done"); end
    n_checks++; if (done_cycle !== acc_cycle + 1) begin n_fail++; $display("FAIL zero_done_latency got=%0d want=%0d", done_cycle, acc_cycle + 1); end
    n_checks++; if (arv_cycles !== vb || ar_count !== ab) begin n_fail++; $display("FAIL zero_no_ar got=%0d/%0d want=0/0", arv_cycles - vb, ar_count - ab); end
    n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL zero_error got=%b want=0", done_err); end
  endtask

  task automatic test_stall_slverr();
    int rb = rx_count; int db = done_count; bit ok = 1'b0;
    err_at = s_beats_total + 4;
    err_en = 1'b1;
    issue_cmd(16'h0200, 16'd20);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_count > db) begin ok = 1'b1; break; end
      if ((c >= 3 && c < 13) || (c >= 30 && c < 40)) m_axis_tready = 1'b0;
      else m_axis_tready = 1'($urandom_range(0, 1));
    end
    m_axis_tready = 1'b1;
    err_en = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout got=none want=done"); end
    n_checks++; if (rx_count - rb !== 20) begin n_fail++; $display("FAIL stall_words got=%0d want=20", rx_count - rb); end
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (rx_data[rb+i] !== 32'h80 + 32'(i)) begin n_fail++; $display("FAIL stall_word%0d got=%h want=%h", i, rx_data[rb+i], 32'h80 + 32'(i)); end
    end
    n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL stall_error got=%b want=1", done_err); end
  endtask

  task automatic test_reset_mid_burst();
    int rb = rx_count; int ab; int db; bit ok = 1'b0;
    m_axis_tready = 1'b1;
    issue_cmd(16'h0300, 16'd8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_count - rb >= 3) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_beats_timeout got=%0d want=3", rx_count - rb); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin n_fail++; $display("FAIL rstmid_handshakes got=%b%b want=00", m_axi_arvalid, m_axi_rready); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle busy=%b cmd_ready=%b want=0/1", busy, cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    ab = ar_count; rb = rx_count; db = done_count;
    issue_cmd(16'h0010, 16'd2);
    wait_done(db, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout got=none want=done"); end
    n_checks++; if (ar_count - ab !== 1 || ar_addr_log[ab] !== 16'h0010 || ar_len_log[ab] !== 8'd1) begin n_fail++; $display("FAIL rstmid_ar got=%0d:%h/%0d want=1:0010/1", ar_count - ab, ar_addr_log[ab], ar_len_log[ab]); end
    n_checks++; if (rx_count - rb !== 2 || rx_data[rb] !== 32'h4 || rx_data[rb+1] !== 32'h5 || rx_last[rb+1] !== 1'b1) begin n_fail++; $display("FAIL rstmid_data got=%0d:%h,%h want=2:4,5", rx_count - rb, rx_data[rb], rx_data[rb+1]); end
    n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_error got=%b want=0", done_err); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_boundary();
    test_zero_len();
    test_stall_slverr();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
